instr_encoder_loader: RTL and testbench

- Reverse direction of the opcode decoder. Accepts symbolic instruction requests (class code plus fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word and writes it sequentially into program (instruction) memory.
- Used by the testbench/boot path to fill ROM-replacement RAM before the core is released from stall.

---
 rtl/instr_encoder_loader_pkg.sv | 35 +++
 rtl/instr_encoder_loader_encoder.sv | 38 +++
 rtl/instr_encoder_loader.sv | 141 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: class codes, MIPS
// opcodes (matching the control unit) and the loader FSM state encoding.
package instr_encoder_loader_pkg;

  localparam logic [3:0] CLS_R    = 4'd0;
  localparam logic [3:0] CLS_ADDI = 4'd1;
  localparam logic [3:0] CLS_ORI  = 4'd2;
  localparam logic [3:0] CLS_ANDI = 4'd3;
  localparam logic [3:0] CLS_BEQ  = 4'd4;
  localparam logic [3:0] CLS_BNE  = 4'd5;
  localparam logic [3:0] CLS_LW   = 4'd6;
  localparam logic [3:0] CLS_SW   = 4'd7;
  localparam logic [3:0] CLS_LUI  = 4'd8;
  localparam logic [3:0] CLS_J    = 4'd9;
  localparam logic [3:0] CLS_JAL  = 4'd10;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_encoder_loader_encoder.sv
// Combinational encoder turning a symbolic request (class code + fields)
// into a 32-bit MIPS word, flagging class codes with no encoding.
module instr_word_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Each format picks only its own fields, so stray values elsewhere never leak in.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_R:    word = {OP_R, rs, rt, rd, shamt, funct};
      CLS_ADDI: word = {OP_ADDI, rs, rt, imm16};
      CLS_ORI:  word = {OP_ORI, rs, rt, imm16};
      CLS_ANDI: word = {OP_ANDI, rs, rt, imm16};
      CLS_BEQ:  word = {OP_BEQ, rs, rt, imm16};
      CLS_BNE:  word = {OP_BNE, rs, rt, imm16};
      CLS_LW:   word = {OP_LW, rs, rt, imm16};
      CLS_SW:   word = {OP_SW, rs, rt, imm16};
      CLS_LUI:  word = {OP_LUI, 5'd0, rt, imm16};
      CLS_J:    word = {OP_J, target};
      CLS_JAL:  word = {OP_JAL, target};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loader that accepts symbolic instruction requests, encodes them and writes
// the words sequentially into program memory starting at BASE_ADDR.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cls,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [4:0]       shamt,
  input  logic [5:0]       funct,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             full,
  output logic             err_illegal
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0] count_inc;
  logic [31:0]      enc_word;
  logic             enc_illegal;

  instr_word_encoder u_encoder (
    .cls     (cls),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .funct   (funct),
    .imm16   (imm16),
    .target  (target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    in_ready    = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
          full_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        in_ready = (count_q != DEPTH_CNT);
        if (in_valid && in_ready) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + (32'(count_q) << 2);
            mem_wdata_d = enc_word;
            count_d     = count_inc;
            if (count_inc == DEPTH_CNT) begin
              full_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        // A finish coinciding with an accept still lets that word be written.
        if (finish) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
          full_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign count       = count_q;
  assign full        = full_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader, built with DEPTH=4
// so the full/DONE boundary is reachable with a handful of words.
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic             finish;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cls;
  logic [4:0]       rs, rt, rd, shamt;
  logic [5:0]       funct;
  logic [15:0]      imm16;
  logic [25:0]      target;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             full;
  logic             err_illegal;

  int n_checks;
  int n_fail;

  instr_encoder_loader #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (32'h0040_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .finish      (finish),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cls         (cls),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16),
    .target      (target),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .count       (count),
    .done        (done),
    .full        (full),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] c, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                         input logic [15:0] im, input logic [25:0] tg);
    cls = c; rs = s; rt = t; rd = d; shamt = sh; funct = f; imm16 = im; target = tg;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    set_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    in_valid = 1'b1;
    tick();
    // Reset lands mid-cycle while a request is still offered.
    #2 reset = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_we got %b want 0", mem_we); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_count got %0d want 0", count); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done got %b want 0", done); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready got %b want 0", in_ready); end
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_in_ready got %b want 0", in_ready); end
    n_checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin n_fail++; $display("[TB] FAIL idle_no_write got we=%b cnt=%0d want 0/0", mem_we, count); end
    in_valid = 1'b0;
  endtask

  task automatic test_single_addi();
    pulse_start();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL load_in_ready got %b want 1", in_ready); end
    set_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_we got %b want 1", mem_we); end
    n_checks++; if (mem_addr !== 32'h0040_0000) begin n_fail++; $display("[TB] FAIL addi_addr got %h want 00400000", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h2022_0005) begin n_fail++; $display("[TB] FAIL addi_wdata got %h want 20220005", mem_wdata); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("[TB] FAIL addi_count got %0d want 1", count); end
    tick();
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL addi_pulse got %b want 0", mem_we); end
    pulse_finish();
    n_checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL finish_done got done=%b rdy=%b want 1/0", done, in_ready); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    n_checks++; if (count !== 3'd0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL restart got cnt=%0d done=%b want 0/0", count, done); end
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h3FF_FFFF);
    in_valid = 1'b1;
    tick();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0040_0000 || mem_wdata !== 32'h0022_1820) begin n_fail++; $display("[TB] FAIL b2b_r got we=%b %h %h want 1 00400000 00221820", mem_we, mem_addr, mem_wdata); end
    set_req(4'd9, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h010_0000);
    tick();
    in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0040_0004 || mem_wdata !== 32'h0810_0000) begin n_fail++; $display("[TB] FAIL b2b_j got we=%b %h %h want 1 00400004 08100000", mem_we, mem_addr, mem_wdata); end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("[TB] FAIL b2b_count got %0d want 2", count); end
    tick();
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_we got %b want 0", mem_we); end
  endtask

  task automatic test_illegal();
    set_req(4'd12, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_we got %b want 0", mem_we); end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("[TB] FAIL illegal_count got %0d want 2", count); end
    n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_err got %b want 1", err_illegal); end
    set_req(4'd8, 5'd5, 5'd1, 5'd9, 5'd9, 6'h3F, 16'h1001, 26'h3FF_FFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0040_0008 || mem_wdata !== 32'h3C01_1001) begin n_fail++; $display("[TB] FAIL lui got we=%b %h %h want 1 00400008 3c011001", mem_we, mem_addr, mem_wdata); end
    n_checks++; if (err_illegal !== 1'b1 || count !== 3'd3) begin n_fail++; $display("[TB] FAIL err_sticky got err=%b cnt=%0d want 1/3", err_illegal, count); end
    pulse_finish();
  endtask

  task automatic test_full();
    pulse_start();
    n_checks++; if (err_illegal !== 1'b0 || full !== 1'b0 || count !== 3'd0) begin n_fail++; $display("[TB] FAIL start_clear got err=%b full=%b cnt=%0d want 0/0/0", err_illegal, full, count); end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0);
      if (i == 4) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_in_ready got %b want 0", in_ready); end
      end
      tick();
      if (i < 4) begin
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== (32'h0040_0000 + 32'(4 * i)) || mem_wdata !== (32'h2022_0000 | 32'(i))) begin n_fail++; $display("[TB] FAIL full_word%0d got we=%b %h %h", i, mem_we, mem_addr, mem_wdata); end
      end else begin
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL fifth_word got we=%b want 0", mem_we); end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd4 || full !== 1'b1 || done !== 1'b1) begin n_fail++; $display("[TB] FAIL full_state got cnt=%0d full=%b done=%b want 4/1/1", count, full, done); end
  endtask

  task automatic test_finish_accept();
    pulse_start();
    set_req(4'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
    in_valid = 1'b1;
    tick();
    n_checks++; if (mem_wdata !== 32'h3464_00FF || count !== 3'd1) begin n_fail++; $display("[TB] FAIL ori got %h cnt=%0d want 346400ff/1", mem_wdata, count); end
    set_req(4'd5, 5'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0040_0004 || mem_wdata !== 32'h1480_FFFE) begin n_fail++; $display("[TB] FAIL bne_finish got we=%b %h %h want 1 00400004 1480fffe", mem_we, mem_addr, mem_wdata); end
    n_checks++; if (done !== 1'b1 || count !== 3'd2) begin n_fail++; $display("[TB] FAIL finish_state got done=%b cnt=%0d want 1/2", done, count); end
    in_valid = 1'b1;
    tick();
    n_checks++; if (mem_we !== 1'b0 || count !== 3'd2) begin n_fail++; $display("[TB] FAIL done_ignores got we=%b cnt=%0d want 0/2", mem_we, count); end
    in_valid = 1'b0;
    pulse_start();
    n_checks++; if (count !== 3'd0 || in_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL new_session got cnt=%0d rdy=%b done=%b want 0/1/0", count, in_ready, done); end
    set_req(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0010);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0040_0000 || mem_wdata !== 32'h0C00_0010) begin n_fail++; $display("[TB] FAIL jal_restart got we=%b %h %h want 1 00400000 0c000010", mem_we, mem_addr, mem_wdata); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    in_valid = 1'b0;
    set_req(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    test_reset();
    test_single_addi();
    test_back_to_back();
    test_illegal();
    test_full();
    test_finish_accept();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
